// File: rtl/sd_cmd_queue_engine_if.sv
// Bus bundle for sd_cmd_queue_engine: command push, CMD pin, response handshake and status.
// With SD_CMD_ABORT_EN defined the bundle also carries cmd_abort.
interface sd_cmd_queue_engine_if #(
   parameter int QUEUE_DEPTH = 4
);
   localparam int LW = $clog2(QUEUE_DEPTH) + 1;

   logic          sd_clk_en;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [5:0]    cmd_index;
   logic [31:0]   cmd_argument;
   logic [1:0]    resp_type;
   logic          crc_check_en;
   logic          index_check_en;
   logic          cmd_pin_in;
   logic          cmd_pin_out;
   logic          cmd_pin_oe;
   logic [127:0]  response;
   logic          resp_valid;
   logic          resp_ack;
   logic [3:0]    err_status;
   logic          busy;
   logic [LW-1:0] queue_level;
`ifdef SD_CMD_ABORT_EN
   logic          cmd_abort;

   modport slave (
      input  sd_clk_en, cmd_valid, cmd_index, cmd_argument, resp_type, crc_check_en,
             index_check_en, cmd_pin_in, resp_ack, cmd_abort,
      output cmd_ready, cmd_pin_out, cmd_pin_oe, response, resp_valid, err_status, busy,
             queue_level
   );
   modport master (
      output sd_clk_en, cmd_valid, cmd_index, cmd_argument, resp_type, crc_check_en,
             index_check_en, cmd_pin_in, resp_ack, cmd_abort,
      input  cmd_ready, cmd_pin_out, cmd_pin_oe, response, resp_valid, err_status, busy,
             queue_level
   );
`else
   modport slave (
      input  sd_clk_en, cmd_valid, cmd_index, cmd_argument, resp_type, crc_check_en,
             index_check_en, cmd_pin_in, resp_ack,
      output cmd_ready, cmd_pin_out, cmd_pin_oe, response, resp_valid, err_status, busy,
             queue_level
   );
   modport master (
      output sd_clk_en, cmd_valid, cmd_index, cmd_argument, resp_type, crc_check_en,
             index_check_en, cmd_pin_in, resp_ack,
      input  cmd_ready, cmd_pin_out, cmd_pin_oe, response, resp_valid, err_status, busy,
             queue_level
   );
`endif
endinterface

// File: rtl/sd_cmd_queue_engine.sv
// Queued SD CMD-line engine: serialises 48-bit command frames and collects none/48/136-bit
// responses with timeout/CRC/end-bit/index checks. SD_CMD_ABORT_EN adds a cmd_abort input.
//
// state | meaning
// IDLE  | waiting for a queued command with no completion pending
// LOAD  | pop FIFO head, build frame with CRC7
// SEND  | drive frame MSB first on ticks, release line after end bit
// WAIT  | count NCR ticks until response start bit or timeout
// RECV  | shift in remaining response bits
// DONE  | latch response/errors, hold resp_valid until acknowledged
module sd_cmd_queue_engine #(
   parameter int QUEUE_DEPTH = 4,
   parameter int NCR_MAX     = 64
) (
   input logic                  i_clock,
   input logic                  i_reset,
   sd_cmd_queue_engine_if.slave bus
);
   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int LW = AW + 1;
   localparam int NW = $clog2(NCR_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SEND, S_WAIT, S_RECV, S_DONE
   } state_t;

   state_t        r_state;
   logic [41:0]   r_q_mem [QUEUE_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic [5:0]    r_cur_idx;
   logic [1:0]    r_cur_type;
   logic          r_cur_crc_en;
   logic          r_cur_ichk;
   logic [47:0]   r_tx;
   logic [5:0]    r_bit_cnt;
   logic [NW-1:0] r_ncr;
   logic [127:0]  r_rx;
   logic [7:0]    r_rx_cnt;
   logic [6:0]    r_rx_crc;
   logic          r_timeout;
   logic          r_out;
   logic          r_oe;
   logic          r_resp_valid;
   logic [127:0]  r_response;
   logic [3:0]    r_err;

   logic          w_ready;
   logic          w_push;
   logic          w_pop;
   logic          w_abort;
   logic [41:0]   w_head;
   logic [39:0]   w_frame_body;
   logic          w_is136;
   logic          w_crc_window;
   logic          w_end_err;
   logic          w_crc_err;
   logic          w_idx_err;
   logic [127:0]  w_resp;

   function automatic logic [6:0] f_crc7_step(input logic [6:0] c, input logic b);
      logic       fb;
      logic [6:0] n;
      fb = c[6] ^ b;
      n  = {c[5:0], 1'b0};
      if (fb) n = n ^ 7'h09;
      return n;
   endfunction

   function automatic logic [6:0] f_crc7_40(input logic [39:0] d);
      logic [6:0] c;
      c = '0;
      for (int i = 39; i >= 0; i--) c = f_crc7_step(c, d[i]);
      return c;
   endfunction

`ifdef SD_CMD_ABORT_EN
   assign w_abort = bus.cmd_abort && (r_state != S_IDLE);
`else
   assign w_abort = 1'b0;
`endif

   assign w_ready      = (r_level != LW'(QUEUE_DEPTH));
   assign w_push       = bus.cmd_valid && w_ready;
   assign w_pop        = (r_state == S_LOAD);
   assign w_head       = r_q_mem[r_rd_ptr];
   assign w_frame_body = {2'b01, w_head[41:36], w_head[35:4]};
   assign w_is136      = (r_cur_type == 2'b01);
   // CRC covers frame bits [47:8] (48-bit) or [127:8] (136-bit); r_rx_cnt is the bit position
   assign w_crc_window = (r_rx_cnt >= 8'd8) && (r_rx_cnt <= (w_is136 ? 8'd127 : 8'd47));
   assign w_end_err    = ~r_rx[0];
   assign w_crc_err    = r_cur_crc_en && (r_rx[7:1] != r_rx_crc);
   assign w_idx_err    = r_cur_ichk && !w_is136 && (r_rx[45:40] != r_cur_idx);
   assign w_resp       = w_is136 ? {8'h00, r_rx[127:8]} : {96'h0, r_rx[39:8]};

   always_ff @(posedge i_clock) begin
      if (w_push) r_q_mem[r_wr_ptr] <= {bus.cmd_index, bus.cmd_argument, bus.resp_type,
                                        bus.crc_check_en, bus.index_check_en};
   end

   always_ff @(posedge i_clock) begin
      if (i_reset || w_abort) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset || w_abort) begin
         r_state      <= S_IDLE;
         r_out        <= 1'b1;
         r_oe         <= 1'b0;
         r_resp_valid <= 1'b0;
         r_response   <= '0;
         r_err        <= '0;
         r_cur_idx    <= '0;
         r_cur_type   <= '0;
         r_cur_crc_en <= 1'b0;
         r_cur_ichk   <= 1'b0;
         r_tx         <= '0;
         r_bit_cnt    <= '0;
         r_ncr        <= '0;
         r_rx         <= '0;
         r_rx_cnt     <= '0;
         r_rx_crc     <= '0;
         r_timeout    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if ((r_level != '0) && !r_resp_valid) r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_cur_idx    <= w_head[41:36];
               r_cur_type   <= w_head[3:2];
               r_cur_crc_en <= w_head[1];
               r_cur_ichk   <= w_head[0];
               r_tx         <= {w_frame_body, f_crc7_40(w_frame_body), 1'b1};
               r_bit_cnt    <= 6'd48;
               r_timeout    <= 1'b0;
               r_state      <= S_SEND;
            end
            S_SEND: begin
               if (bus.sd_clk_en) begin
                  if (r_bit_cnt != '0) begin
                     r_out     <= r_tx[47];
                     r_oe      <= 1'b1;
                     r_tx      <= {r_tx[46:0], 1'b0};
                     r_bit_cnt <= r_bit_cnt - 6'd1;
                  end else begin
                     r_out <= 1'b1;
                     r_oe  <= 1'b0;
                     r_ncr <= NW'(NCR_MAX - 1);
                     r_state <= (r_cur_type == 2'b00) ? S_DONE : S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (bus.sd_clk_en) begin
                  if (!bus.cmd_pin_in) begin
                     r_rx     <= '0;
                     r_rx_crc <= '0;
                     r_rx_cnt <= w_is136 ? 8'd134 : 8'd46;
                     r_state  <= S_RECV;
                  end else if (r_ncr == '0) begin
                     r_timeout <= 1'b1;
                     r_state   <= S_DONE;
                  end else begin
                     r_ncr <= r_ncr - NW'(1);
                  end
               end
            end
            S_RECV: begin
               if (bus.sd_clk_en) begin
                  r_rx <= {r_rx[126:0], bus.cmd_pin_in};
                  if (w_crc_window) r_rx_crc <= f_crc7_step(r_rx_crc, bus.cmd_pin_in);
                  if (r_rx_cnt == 8'd0) r_state <= S_DONE;
                  else                  r_rx_cnt <= r_rx_cnt - 8'd1;
               end
            end
            S_DONE: begin
               if (!r_resp_valid) begin
                  r_resp_valid <= 1'b1;
                  if (r_timeout) begin
                     r_response <= '0;
                     r_err      <= 4'b0001;
                  end else if (r_cur_type == 2'b00) begin
                     r_response <= '0;
                     r_err      <= 4'b0000;
                  end else begin
                     r_response <= w_resp;
                     r_err      <= {w_idx_err, w_end_err, w_crc_err, 1'b0};
                  end
               end else if (bus.resp_ack) begin
                  r_resp_valid <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready   = w_ready;
   assign bus.cmd_pin_out = r_out;
   assign bus.cmd_pin_oe  = r_oe;
   assign bus.response    = r_response;
   assign bus.resp_valid  = r_resp_valid;
   assign bus.err_status  = r_err;
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.queue_level = r_level;
endmodule

// File: tb/tb_sd_cmd_queue_engine.sv
// Directed bench for sd_cmd_queue_engine: frames, responses, error flags, queueing and reset.
module tb_sd_cmd_queue_engine;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sd_cmd_queue_engine_if #(.QUEUE_DEPTH(4)) bus ();
   sd_cmd_queue_engine #(.QUEUE_DEPTH(4), .NCR_MAX(64)) dut (
      .i_clock(clk), .i_reset(rst), .bus(bus)
   );

   int tests = 0;
   int fails = 0;

   function automatic logic [6:0] crc7(input logic [127:0] d, input int n);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = n - 1; i >= 0; i--) begin
         fb = c[6] ^ d[i];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic logic [47:0] mkframe(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] b;
      b = {2'b01, idx, arg};
      return {b, crc7({88'h0, b}, 40), 1'b1};
   endfunction

   function automatic logic [47:0] r48(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] b;
      b = {2'b00, idx, arg};
      return {b, crc7({88'h0, b}, 40), 1'b1};
   endfunction

   task automatic tick(input logic pin);
      bus.cmd_pin_in = pin;
      bus.sd_clk_en  = 1'b1;
      @(negedge clk);
      bus.sd_clk_en  = 1'b0;
      bus.cmd_pin_in = 1'b1;
      @(negedge clk);
   endtask

   task automatic push(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                       input logic ce, input logic ie, output logic acc);
      bus.cmd_index      = idx;
      bus.cmd_argument   = arg;
      bus.resp_type      = rt;
      bus.crc_check_en   = ce;
      bus.index_check_en = ie;
      acc                = bus.cmd_ready;
      bus.cmd_valid      = 1'b1;
      @(negedge clk);
      bus.cmd_valid      = 1'b0;
   endtask

   task automatic xmit(input logic [47:0] exp, input string nm, output int pre);
      logic [47:0] got;
      logic        oe_ok;
      pre   = 0;
      oe_ok = 1'b1;
      got   = '0;
      tick(1'b1);
      while (!bus.cmd_pin_oe && pre < 10) begin
         pre++;
         tick(1'b1);
      end
      tests++;
      if (bus.cmd_pin_oe !== 1'b1) begin
         fails++;
         $display("FAIL %s start: cmd_pin_oe never rose within 10 ticks", nm);
         return;
      end
      got[47] = bus.cmd_pin_out;
      for (int i = 46; i >= 0; i--) begin
         tick(1'b1);
         got[i] = bus.cmd_pin_out;
         if (bus.cmd_pin_oe !== 1'b1) oe_ok = 1'b0;
      end
      tests++;
      if (got !== exp || !oe_ok) begin
         fails++;
         $display("FAIL %s frame: got %h oe_ok %b, expected %h oe_ok 1", nm, got, oe_ok, exp);
      end
      tick(1'b1);
      tests++;
      if ({bus.cmd_pin_oe, bus.cmd_pin_out} !== 2'b01) begin
         fails++;
         $display("FAIL %s release: oe/out %b%b, expected 01", nm, bus.cmd_pin_oe, bus.cmd_pin_out);
      end
   endtask

   task automatic card(input logic [135:0] bits, input int len, input int gap);
      for (int i = 0; i < gap; i++) tick(1'b1);
      for (int i = len - 1; i >= 0; i--) tick(bits[i]);
   endtask

   task automatic wait_resp(input string nm);
      int n = 0;
      while (bus.resp_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (bus.resp_valid !== 1'b1) begin
         fails++;
         $display("FAIL %s resp_valid: got %b within 20 cycles, expected 1", nm, bus.resp_valid);
      end
   endtask

   task automatic check_resp(input string nm, input logic [127:0] er, input logic [3:0] ee);
      tests++;
      if (bus.response !== er) begin
         fails++;
         $display("FAIL %s response: got %h expected %h", nm, bus.response, er);
      end
      tests++;
      if (bus.err_status !== ee) begin
         fails++;
         $display("FAIL %s err_status: got %b expected %b", nm, bus.err_status, ee);
      end
   endtask

   task automatic ack();
      bus.resp_ack = 1'b1;
      @(negedge clk);
      bus.resp_ack = 1'b0;
   endtask

   task automatic run48(input string nm, input logic [5:0] idx, input logic [31:0] arg,
                        input logic ce, input logic ie, input logic [47:0] exp_frame,
                        input logic [47:0] rsp, input logic [127:0] er, input logic [3:0] ee);
      logic acc;
      int   pre;
      push(idx, arg, 2'b10, ce, ie, acc);
      xmit(exp_frame, nm, pre);
      card({88'h0, rsp}, 48, 4);
      wait_resp(nm);
      check_resp(nm, er, ee);
      ack();
   endtask

   task automatic test_reset();
      tests++;
      if ({bus.cmd_pin_out, bus.cmd_pin_oe, bus.resp_valid, bus.busy, bus.cmd_ready} !== 5'b10001) begin
         fails++;
         $display("FAIL reset flags: out/oe/valid/busy/ready got %b expected 10001",
                  {bus.cmd_pin_out, bus.cmd_pin_oe, bus.resp_valid, bus.busy, bus.cmd_ready});
      end
      check_resp("reset", 128'h0, 4'b0000);
      tests++;
      if (bus.queue_level !== 3'd0) begin
         fails++;
         $display("FAIL reset queue_level: got %0d expected 0", bus.queue_level);
      end
      ack();
      @(negedge clk);
      tests++;
      if ({bus.resp_valid, bus.busy} !== 2'b00) begin
         fails++;
         $display("FAIL stray_ack: valid/busy got %b expected 00", {bus.resp_valid, bus.busy});
      end
   endtask

   task automatic test_cmd0();
      logic acc;
      int   pre;
      push(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, acc);
      repeat (2) @(negedge clk);
      xmit(48'h400000000095, "cmd0", pre);
      tests++;
      if (pre != 0) begin
         fails++;
         $display("FAIL cmd0 latency: got %0d idle ticks expected 0", pre);
      end
      wait_resp("cmd0");
      check_resp("cmd0", 128'h0, 4'b0000);
      ack();
      tests++;
      if ({bus.resp_valid, bus.busy} !== 2'b00) begin
         fails++;
         $display("FAIL cmd0 after_ack: valid/busy got %b expected 00", {bus.resp_valid, bus.busy});
      end
   endtask

   task automatic test_cmd8_ok();
      run48("cmd8", 6'd8, 32'h000001AA, 1'b1, 1'b1, 48'h48000001AA87, 48'h08000001AA13,
            128'h1AA, 4'b0000);
   endtask

   task automatic test_timeout();
      logic acc;
      int   pre;
      push(6'd8, 32'h000001AA, 2'b10, 1'b1, 1'b1, acc);
      xmit(48'h48000001AA87, "timeout", pre);
      repeat (63) tick(1'b1);
      tests++;
      if ({bus.resp_valid, bus.busy} !== 2'b01) begin
         fails++;
         $display("FAIL timeout early: valid/busy got %b expected 01 after 63 ticks",
                  {bus.resp_valid, bus.busy});
      end
      tick(1'b1);
      wait_resp("timeout");
      check_resp("timeout", 128'h0, 4'b0001);
      ack();
   endtask

   task automatic test_errors();
      logic [47:0] f8;
      f8 = mkframe(6'd8, 32'h1AA);
      run48("end_bit", 6'd8, 32'h1AA, 1'b1, 1'b1, f8, 48'h08000001AA12, 128'h1AA, 4'b0100);
      run48("crc_bad", 6'd8, 32'h1AA, 1'b1, 1'b1, f8, 48'h08000001AA15, 128'h1AA, 4'b0010);
      run48("crc_off", 6'd8, 32'h1AA, 1'b0, 1'b1, f8, 48'h08000001AA15, 128'h1AA, 4'b0000);
      run48("idx_bad", 6'd8, 32'h1AA, 1'b1, 1'b1, f8, r48(6'd9, 32'h1AA), 128'h1AA, 4'b1000);
      run48("idx_off", 6'd8, 32'h1AA, 1'b1, 1'b0, f8, r48(6'd9, 32'h1AA), 128'h1AA, 4'b0000);
   endtask

   task automatic test_r136();
      logic [119:0] pay;
      logic [135:0] bits;
      logic         acc;
      int           pre;
      pay  = 120'h0123456789ABCDEFFEDCBA98765432;
      bits = {8'h3F, pay, crc7({8'h0, pay}, 120), 1'b1};
      push(6'd2, 32'h0, 2'b01, 1'b1, 1'b1, acc);
      xmit(mkframe(6'd2, 32'h0), "r136", pre);
      card(bits, 136, 3);
      wait_resp("r136");
      check_resp("r136", {8'h00, pay}, 4'b0000);
      ack();
   endtask

   task automatic test_queue();
      logic acc;
      int   pre;
      push(6'd0, 32'h11, 2'b00, 1'b0, 1'b0, acc);
      xmit(mkframe(6'd0, 32'h11), "q_head", pre);
      wait_resp("q_head");
      for (int i = 1; i <= 5; i++) begin
         push(6'(i), 32'(i * 256), 2'b00, 1'b0, 1'b0, acc);
         tests++;
         if (acc !== (i <= 4)) begin
            fails++;
            $display("FAIL q_push%0d cmd_ready: got %b expected %b", i, acc, (i <= 4));
         end
      end
      tests++;
      if ({bus.queue_level, bus.cmd_ready, bus.resp_valid} !== {3'd4, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL q_full level/ready/valid: got %0d/%b/%b expected 4/0/1",
                  bus.queue_level, bus.cmd_ready, bus.resp_valid);
      end
      for (int k = 1; k <= 4; k++) begin
         ack();
         xmit(mkframe(6'(k), 32'(k * 256)), "q_drain", pre);
         wait_resp("q_drain");
         check_resp("q_drain", 128'h0, 4'b0000);
      end
      ack();
      repeat (3) @(negedge clk);
      tests++;
      if ({bus.queue_level, bus.busy} !== {3'd0, 1'b0}) begin
         fails++;
         $display("FAIL q_empty level/busy: got %0d/%b expected 0/0", bus.queue_level, bus.busy);
      end
   endtask

   task automatic start_two_and_send20(input string nm);
      logic acc;
      int   n = 0;
      push(6'd8, 32'h1AA, 2'b10, 1'b1, 1'b1, acc);
      push(6'd3, 32'h0, 2'b00, 1'b0, 1'b0, acc);
      tick(1'b1);
      while (!bus.cmd_pin_oe && n < 10) begin
         n++;
         tick(1'b1);
      end
      repeat (19) tick(1'b1);
      tests++;
      if ({bus.cmd_pin_oe, bus.queue_level} !== {1'b1, 3'd1}) begin
         fails++;
         $display("FAIL %s mid_send oe/level: got %b/%0d expected 1/1", nm, bus.cmd_pin_oe,
                  bus.queue_level);
      end
   endtask

   task automatic check_aborted(input string nm);
      tests++;
      if ({bus.cmd_pin_out, bus.cmd_pin_oe, bus.resp_valid, bus.busy, bus.queue_level} !==
          {4'b1000, 3'd0}) begin
         fails++;
         $display("FAIL %s state: out/oe/valid/busy/level got %b%b%b%b/%0d expected 1000/0", nm,
                  bus.cmd_pin_out, bus.cmd_pin_oe, bus.resp_valid, bus.busy, bus.queue_level);
      end
   endtask

   task automatic test_reset_mid();
      start_two_and_send20("rst_mid");
      rst = 1'b1;
      @(negedge clk);
      check_aborted("rst_mid");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_aborted("rst_mid_after");
   endtask

`ifdef SD_CMD_ABORT_EN
   task automatic test_abort();
      logic acc;
      int   pre;
      start_two_and_send20("abort_mid");
      bus.cmd_abort = 1'b1;
      @(negedge clk);
      bus.cmd_abort = 1'b0;
      check_aborted("abort_mid");
      push(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, acc);
      xmit(mkframe(6'd0, 32'h0), "abort_done", pre);
      wait_resp("abort_done");
      bus.cmd_abort = 1'b1;
      @(negedge clk);
      bus.cmd_abort = 1'b0;
      check_aborted("abort_done");
   endtask
`endif

   initial begin
      bus.sd_clk_en      = 1'b0;
      bus.cmd_valid      = 1'b0;
      bus.cmd_index      = '0;
      bus.cmd_argument   = '0;
      bus.resp_type      = '0;
      bus.crc_check_en   = 1'b0;
      bus.index_check_en = 1'b0;
      bus.cmd_pin_in     = 1'b1;
      bus.resp_ack       = 1'b0;
`ifdef SD_CMD_ABORT_EN
      bus.cmd_abort      = 1'b0;
`endif
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_cmd0();
      test_cmd8_ok();
      test_timeout();
      test_errors();
      test_r136();
      test_queue();
      test_reset_mid();
`ifdef SD_CMD_ABORT_EN
      test_abort();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded 2 ms, tests run %0d", tests);
      $fatal(1, "watchdog");
   end
endmodule
